cat_door_controller: RTL and testbench

// Sequential stage downstream of cat_selector: consumes its IsMyCat verdict and drives a cat flap.

---
 rtl/cat_door_controller.sv | 131 +++++++++++++
 tb/tb_cat_door_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cat_door_controller.sv
// Cat flap controller: debounces presence, samples the IsMyCat verdict once per visit,
// opens the door for admitted cats and keeps saturating admit/reject statistics.
// Optional stranger alarm enabled by defining CAT_DOOR_ALARM_EN.
module cat_door_controller #(
    parameter int SETTLE_CYCLES = 2,
    parameter int OPEN_CYCLES   = 8,
    parameter int CNT_W         = 8,
    parameter int ALARM_THRESH  = 3
) (
    input  logic             Clk,
    input  logic             RstN,
    input  logic             CatPresent,
    input  logic             IsMyCat,
    input  logic             AlarmClr,
    output logic             DoorOpen,
    output logic             Busy,
    output logic [CNT_W-1:0] AdmitCount,
    output logic [CNT_W-1:0] RejectCount,
    output logic             Alarm
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int OW = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [OW-1:0] OPEN_LAST   = OW'(OPEN_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, OPEN, WAIT_CLEAR} state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   settle_cnt, settle_nxt;
    logic [OW-1:0]   open_cnt, open_nxt;
    logic            admit, reject;

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state      <= IDLE;
            settle_cnt <= '0;
            open_cnt   <= '0;
            DoorOpen   <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_nxt;
            open_cnt   <= open_nxt;
            // Outputs are flopped from the next state so they line up with the state register
            DoorOpen   <= (state_nxt == OPEN);
            Busy       <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt  = state;
        settle_nxt = settle_cnt;
        open_nxt   = open_cnt;
        admit      = 1'b0;
        reject     = 1'b0;
        case (state)
            IDLE: begin
                if (CatPresent) begin
                    state_nxt  = SETTLE;
                    settle_nxt = '0;
                end
            end
            SETTLE: begin
                if (!CatPresent) begin
                    state_nxt = IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    if (IsMyCat) begin
                        state_nxt = OPEN;
                        open_nxt  = '0;
                        admit     = 1'b1;
                    end else begin
                        state_nxt = WAIT_CLEAR;
                        reject    = 1'b1;
                    end
                end else begin
                    settle_nxt = settle_cnt + 1'b1;
                end
            end
            OPEN: begin
                if (open_cnt == OPEN_LAST) state_nxt = WAIT_CLEAR;
                else                       open_nxt  = open_cnt + 1'b1;
            end
            WAIT_CLEAR: begin
                if (!CatPresent) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            AdmitCount  <= '0;
            RejectCount <= '0;
        end else begin
            if (admit && (AdmitCount != '1))   AdmitCount  <= AdmitCount + 1'b1;
            if (reject && (RejectCount != '1)) RejectCount <= RejectCount + 1'b1;
        end
    end

`ifdef CAT_DOOR_ALARM_EN
    localparam int AW = $clog2(ALARM_THRESH + 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_THRESH);

    logic [AW-1:0] streak;
    logic          alarm_q;

    // Clear beats a same-edge reject; the streak parks at the threshold once reached
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            streak  <= '0;
            alarm_q <= 1'b0;
        end else if (AlarmClr) begin
            streak  <= '0;
            alarm_q <= 1'b0;
        end else if (admit) begin
            streak  <= '0;
        end else if (reject && (streak != ALARM_LAST)) begin
            streak <= streak + 1'b1;
            if ((streak + 1'b1) == ALARM_LAST) alarm_q <= 1'b1;
        end
    end

    assign Alarm = alarm_q;
`else
    logic unused_alarm_clr;
    assign unused_alarm_clr = AlarmClr;
    assign Alarm            = 1'b0;
`endif

endmodule

// File: tb/tb_cat_door_controller.sv
// Bench for cat_door_controller: scripted vector table, hand sequences for corner cases,
// and randomized traffic against a visit-level reference model (second instance has CNT_W=2).
module tb_cat_door_controller;

    localparam int SETTLE = 2;
    localparam int OPENC  = 8;
    localparam int THRESH = 3;

    logic       Clk = 1'b0;
    logic       RstN = 1'b0;
    logic       CatPresent = 1'b0;
    logic       IsMyCat = 1'b0;
    logic       AlarmClr = 1'b0;
    logic       DoorOpen, Busy, Alarm;
    logic [7:0] AdmitCount, RejectCount;
    logic       DoorOpen2, Busy2, Alarm2;
    logic [1:0] AdmitCount2, RejectCount2;

    always #5 Clk = ~Clk;

    cat_door_controller #(.SETTLE_CYCLES(SETTLE), .OPEN_CYCLES(OPENC), .CNT_W(8), .ALARM_THRESH(THRESH)) u_dut (
        .Clk(Clk), .RstN(RstN), .CatPresent(CatPresent), .IsMyCat(IsMyCat), .AlarmClr(AlarmClr),
        .DoorOpen(DoorOpen), .Busy(Busy), .AdmitCount(AdmitCount), .RejectCount(RejectCount), .Alarm(Alarm));

    cat_door_controller #(.SETTLE_CYCLES(SETTLE), .OPEN_CYCLES(OPENC), .CNT_W(2), .ALARM_THRESH(THRESH)) u_dut2 (
        .Clk(Clk), .RstN(RstN), .CatPresent(CatPresent), .IsMyCat(IsMyCat), .AlarmClr(AlarmClr),
        .DoorOpen(DoorOpen2), .Busy(Busy2), .AdmitCount(AdmitCount2), .RejectCount(RejectCount2), .Alarm(Alarm2));

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: a visit is a run of present edges, then a door countdown, then a wait for absence
    int m_run, m_door_left, m_admit, m_reject, m_streak;
    bit m_wait, m_alarm;

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_reset();
        m_run = 0; m_door_left = 0; m_wait = 0; m_admit = 0; m_reject = 0;
        m_streak = 0; m_alarm = 0;
    endtask

    task automatic model_edge(input bit cp, input bit mc, input bit clr);
        bit adm, rej;
        adm = 0; rej = 0;
        if (m_door_left > 0) begin
            m_door_left--;
        end else if (m_wait) begin
            if (!cp) m_wait = 0;
        end else if (cp) begin
            m_run++;
            if (m_run == SETTLE + 1) begin
                m_run  = 0;
                m_wait = 1;
                if (mc) begin m_admit++; m_door_left = OPENC; adm = 1; end
                else    begin m_reject++; rej = 1; end
            end
        end else begin
            m_run = 0;
        end
`ifdef CAT_DOOR_ALARM_EN
        if (clr) begin
            m_streak = 0; m_alarm = 0;
        end else if (adm) begin
            m_streak = 0;
        end else if (rej) begin
            m_streak = sat(m_streak + 1, THRESH);
            if (m_streak == THRESH) m_alarm = 1;
        end
`else
        if (clr || adm || rej) m_alarm = 0;
`endif
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model_door",    32'(DoorOpen), 32'(m_door_left > 0));
        chk("model_busy",    32'(Busy), 32'((m_run > 0) || (m_door_left > 0) || m_wait));
        chk("model_admit",   32'(AdmitCount), 32'(sat(m_admit, 255)));
        chk("model_reject",  32'(RejectCount), 32'(sat(m_reject, 255)));
        chk("model_admit2",  32'(AdmitCount2), 32'(sat(m_admit, 3)));
        chk("model_reject2", 32'(RejectCount2), 32'(sat(m_reject, 3)));
        chk("model_alarm",   32'(Alarm), 32'(m_alarm));
    endtask

    // One clock: drive at the falling edge, model the rising edge, sample at the next falling edge
    task automatic step(input bit cp, input bit mc, input bit clr);
        CatPresent = cp; IsMyCat = mc; AlarmClr = clr;
        @(posedge Clk);
        model_edge(cp, mc, clr);
        @(negedge Clk);
        check_model();
    endtask

    task automatic check_zero(input string name);
        chk({name, "_door"},   32'(DoorOpen), 0);
        chk({name, "_busy"},   32'(Busy), 0);
        chk({name, "_admit"},  32'(AdmitCount), 0);
        chk({name, "_reject"}, 32'(RejectCount), 0);
        chk({name, "_alarm"},  32'(Alarm), 0);
    endtask

    // Assert reset between edges; outputs must clear without waiting for a clock
    task automatic async_reset(input string name);
        #2 RstN = 1'b0;
        #1 check_zero(name);
        model_reset();
        CatPresent = 0; IsMyCat = 0; AlarmClr = 0;
        @(negedge Clk);
        RstN = 1'b1;
    endtask

    typedef struct {
        bit cp;
        bit mc;
        bit door;
        bit busy;
        int admit;
        int reject;
    } vec_t;

    vec_t tbl[19];

    initial begin
        bit door_seen;
        int door_cycles;
        bit cp;

        tbl[0] = '{1, 1, 0, 1, 0, 0};
        tbl[1] = '{1, 0, 0, 1, 0, 0};
        tbl[2] = '{1, 1, 1, 1, 1, 0};
        for (int i = 3; i <= 9; i++) tbl[i] = '{0, 0, 1, 1, 1, 0};
        tbl[10] = '{1, 0, 0, 1, 1, 0};
        tbl[11] = '{1, 0, 0, 1, 1, 0};
        tbl[12] = '{0, 0, 0, 0, 1, 0};
        tbl[13] = '{1, 0, 0, 1, 1, 0};
        tbl[14] = '{0, 1, 0, 0, 1, 0};
        tbl[15] = '{1, 0, 0, 1, 1, 0};
        tbl[16] = '{1, 1, 0, 1, 1, 0};
        tbl[17] = '{1, 0, 0, 1, 1, 1};
        tbl[18] = '{0, 0, 0, 0, 1, 1};

        model_reset();
        #1 check_zero("reset");
        @(negedge Clk);
        @(negedge Clk);
        RstN = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) step(0, $urandom_range(0, 1), 0);
        check_zero("idle");

        // Scripted admit, linger, bounce and reject
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].cp, tbl[i].mc, 0);
            chk($sformatf("tbl%0d_door", i),   32'(DoorOpen), 32'(tbl[i].door));
            chk($sformatf("tbl%0d_busy", i),   32'(Busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_admit", i),  32'(AdmitCount), 32'(tbl[i].admit));
            chk($sformatf("tbl%0d_reject", i), 32'(RejectCount), 32'(tbl[i].reject));
        end

        // Our cat lingers long after the door closes: counted once
        async_reset("rst_a");
        for (int i = 0; i < 3; i++) step(1, 1, 0);
        for (int i = 0; i < 28; i++) step(1, $urandom_range(0, 1), 0);
        chk("linger_admit", 32'(AdmitCount), 1);
        chk("linger_busy", 32'(Busy), 1);
        step(0, 0, 0);
        chk("linger_drop_busy", 32'(Busy), 0);

        // Three strangers
        async_reset("rst_b");
        door_seen = 0;
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < 3; i++) begin
                step(1, 0, 0);
                door_seen |= DoorOpen;
            end
            step(0, 0, 0);
        end
        chk("stranger_reject", 32'(RejectCount), 3);
        chk("stranger_door", 32'(door_seen), 0);
`ifdef CAT_DOOR_ALARM_EN
        chk("stranger_alarm", 32'(Alarm), 1);
`else
        chk("stranger_alarm", 32'(Alarm), 0);
`endif
        step(0, 0, 1);
        chk("alarm_clr", 32'(Alarm), 0);

        // Reset during the fourth open cycle
        async_reset("rst_c");
        for (int i = 0; i < 3; i++) step(1, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0);
        chk("open4_door", 32'(DoorOpen), 1);
        async_reset("rst_open");
        step(0, 0, 0);
        check_zero("after_rst_open");

        // Five admissions: 2-bit counter saturates, door still opens each time
        for (int v = 0; v < 5; v++) begin
            door_cycles = 0;
            for (int i = 0; i < 3; i++) step(1, 1, 0);
            door_cycles += int'(DoorOpen);
            for (int i = 0; i < 12; i++) begin
                step(0, 0, 0);
                door_cycles += int'(DoorOpen);
            end
            chk($sformatf("visit%0d_door_cycles", v), door_cycles, OPENC);
        end
        chk("sat_admit2", 32'(AdmitCount2), 3);
        chk("sat_admit8", 32'(AdmitCount), 5);

        // Randomized traffic against the model
        async_reset("rst_rand");
        cp = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) cp = ~cp;
            if ($urandom_range(0, 399) == 0) async_reset("rand_rst");
            else step(cp, $urandom_range(0, 1), $urandom_range(0, 24) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
